// File: rtl/cpu_ctrl_unit_if.sv
// Instruction handshake plus datapath control bundle between the instruction
// source / datapath (master) and the multi-cycle control unit (slave).
interface cpu_ctrl_unit_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned OP_W     = 4,
    parameter int unsigned INSTR_W  = OP_W + 2 * RA_W
);
    logic [INSTR_W-1:0]  instr;
    logic                instr_valid;
    logic                instr_ready;
    logic                zero_flag;
    logic [NUM_REGS-1:0] rf_en;
    logic [NUM_REGS-1:0] rf_oe;
    logic                ext_oe;
    logic                a_en;
    logic                g_en;
    logic                g_oe;
    logic [1:0]          alu_sel;
    logic                br_take;
    logic [2*RA_W-1:0]   br_addr;
    logic                done;
    logic                err;

    modport master (
        output instr, instr_valid, zero_flag,
        input  instr_ready, rf_en, rf_oe, ext_oe, a_en, g_en, g_oe, alu_sel,
        input  br_take, br_addr, done, err
    );

    modport slave (
        input  instr, instr_valid, zero_flag,
        output instr_ready, rf_en, rf_oe, ext_oe, a_en, g_en, g_oe, alu_sel,
        output br_take, br_addr, done, err
    );
endinterface

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle control unit for the shared-bus CPU: accepts one instruction per
// handshake and sequences register-file, A/G latch, ALU and branch controls.
module cpu_ctrl_unit #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned OP_W     = 4,
    parameter int unsigned INSTR_W  = OP_W + 2 * RA_W
) (
    input logic            clk,
    input logic            rst,
    cpu_ctrl_unit_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StMove, StAlu1, StAlu2, StAlu3,
        StBr, StCall1, StCall2, StRet, StErr
    } state_e;

    localparam logic [NUM_REGS-1:0] RegOne = NUM_REGS'(1);
    localparam logic [NUM_REGS-1:0] RfLr   = RegOne << (NUM_REGS - 2);
    localparam logic [NUM_REGS-1:0] RfPc   = RegOne << (NUM_REGS - 1);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               init_q, init_d;
    logic               instr_ready;

    logic [OP_W-1:0]     ir_op;
    logic [RA_W-1:0]     ir_x, ir_y;
    logic [NUM_REGS-1:0] rf_x, rf_y;
    logic                br_take;

    assign ir_op = ir_q[INSTR_W-1 -: OP_W];
    assign ir_x  = ir_q[2*RA_W-1 -: RA_W];
    assign ir_y  = ir_q[RA_W-1:0];
    assign rf_x  = RegOne << ir_x;
    assign rf_y  = RegOne << ir_y;

    // init_q holds ready low through the first cycle after reset release.
    assign instr_ready     = (state_q == StIdle) && init_q;
    assign bus.instr_ready = instr_ready;

    function automatic state_e decode(input logic [OP_W-1:0] op);
        case (op)
            OP_W'(0):                     return StLoad;
            OP_W'(1):                     return StMove;
            OP_W'(2), OP_W'(3),
            OP_W'(4), OP_W'(5):           return StAlu1;
            OP_W'(6), OP_W'(7):           return StBr;
            OP_W'(8):                     return StCall1;
            OP_W'(9):                     return StRet;
            default:                      return StErr;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            init_q  <= init_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        init_d  = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (bus.instr_valid && instr_ready) begin
                    ir_d    = bus.instr;
                    state_d = decode(bus.instr[INSTR_W-1 -: OP_W]);
                end
            end
            StAlu1:  state_d = StAlu2;
            StAlu2:  state_d = StAlu3;
            StCall1: state_d = StCall2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rf_en   = '0;
        bus.rf_oe   = '0;
        bus.ext_oe  = 1'b0;
        bus.a_en    = 1'b0;
        bus.g_en    = 1'b0;
        bus.g_oe    = 1'b0;
        bus.alu_sel = 2'b00;
        bus.done    = 1'b0;
        bus.err     = 1'b0;
        br_take     = 1'b0;
        unique case (state_q)
            StLoad: begin
                bus.ext_oe = 1'b1;
                bus.rf_en  = rf_x;
                bus.done   = 1'b1;
            end
            StMove: begin
                bus.rf_oe = rf_y;
                bus.rf_en = rf_x;
                bus.done  = 1'b1;
            end
            StAlu1: begin
                bus.rf_oe = rf_x;
                bus.a_en  = 1'b1;
            end
            StAlu2: begin
                bus.rf_oe = rf_y;
                bus.g_en  = 1'b1;
                case (ir_op)
                    OP_W'(3): bus.alu_sel = 2'b10;
                    OP_W'(4): bus.alu_sel = 2'b01;
                    OP_W'(5): bus.alu_sel = 2'b11;
                    default:  bus.alu_sel = 2'b00;
                endcase
            end
            StAlu3: begin
                bus.g_oe  = 1'b1;
                bus.rf_en = rf_x;
                bus.done  = 1'b1;
            end
            StBr: begin
                br_take  = (ir_op == OP_W'(6)) || bus.zero_flag;
                bus.done = 1'b1;
            end
            StCall1: begin
                bus.rf_oe = RfPc;
                bus.rf_en = RfLr;
            end
            StCall2: begin
                br_take  = 1'b1;
                bus.done = 1'b1;
            end
            StRet: begin
                bus.rf_oe = RfLr;
                bus.rf_en = RfPc;
                bus.done  = 1'b1;
            end
            StErr: begin
                bus.err  = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
        bus.br_take = br_take;
        bus.br_addr = br_take ? {ir_x, ir_y} : '0;
    end

endmodule
